oam_dma_arbiter: RTL and testbench

Bus arbiter and sequencer for sprite (OAM) DMA in the Q2A03. The block sits between `core` and the system bus. It detects a CPU write to the DMA trigger register and halts the core through its ready input. It then owns the bus to copy `DMA_LENGTH` bytes from page `$XX00` to the PPU OAM data port, and returns the bus to the core. It generates its own bus-cycle timebase that runs in lock-step with the core's divider.

---
 rtl/oam_dma_arbiter_if.sv | 40 ++++
 rtl/oam_dma_arbiter.sv | 139 +++++++++++++
 tb/tb_oam_dma_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if: core-side and system-bus signals of the sprite DMA arbiter.
// slave is the arbiter; master is the core/bus environment driving it.
interface oam_dma_arbiter_if;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_wr_data;
    logic        I_cpu_rdwr;
    logic [7:0]  I_rd_data;
    logic        O_cpu_ready;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic        O_phy2;
    logic        O_dma_busy;

    modport slave (
        input  I_cpu_addr,
        input  I_cpu_wr_data,
        input  I_cpu_rdwr,
        input  I_rd_data,
        output O_cpu_ready,
        output O_addr,
        output O_wr_data,
        output O_rdwr,
        output O_phy2,
        output O_dma_busy
    );

    modport master (
        output I_cpu_addr,
        output I_cpu_wr_data,
        output I_cpu_rdwr,
        output I_rd_data,
        input  O_cpu_ready,
        input  O_addr,
        input  O_wr_data,
        input  O_rdwr,
        input  O_phy2,
        input  O_dma_busy
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: halts the core and copies one page to the OAM data port.
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN dummy cycle.
module oam_dma_arbiter #(
    parameter int unsigned CYCLE_TICKS  = 12,
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DMA_DST_ADDR = 16'h2004,
    parameter int unsigned DMA_LENGTH   = 256
) (
    input  logic             I_clock,
    input  logic             I_reset,
    input  logic             I_ready,
    oam_dma_arbiter_if.slave bus
);
    localparam int unsigned CW =
        (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CYCLE_TICKS / 2);
    localparam logic [7:0]    IDX_LAST = 8'(DMA_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_READ,
        S_WRITE
`ifdef OAM_DMA_ALIGN_EN
        , S_ALIGN
`endif
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    page_q;
    logic [7:0]    index_q;
    logic [7:0]    data_q;
    logic          rdy_q;
    logic          cyc_end;
`ifdef OAM_DMA_ALIGN_EN
    logic          parity_q;
`endif

    // Phase counter advances only while the external ready is high.
    always_comb begin
        cnt_d = cnt_q;
        if (I_ready) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign cyc_end = I_ready && (cnt_q == CNT_LAST);

    // Bus-cycle timebase register.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Transfer sequencer; every update lands on the cycle-end edge.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            index_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b1;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
`endif
        end else if (cyc_end) begin
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= ~parity_q;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.I_cpu_rdwr &&
                        bus.I_cpu_addr == DMA_REG_ADDR) begin
                        page_q  <= bus.I_cpu_wr_data;
                        index_q <= '0;
                        state_q <= S_HALT;
                        rdy_q   <= 1'b0;
                    end
                end
                S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    // Next cycle is odd when this one is even.
                    state_q <= parity_q ? S_READ : S_ALIGN;
`else
                    state_q <= S_READ;
`endif
                end
`ifdef OAM_DMA_ALIGN_EN
                S_ALIGN: state_q <= S_READ;
`endif
                S_READ: begin
                    data_q  <= bus.I_rd_data;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    index_q <= index_q + 8'd1;
                    if (index_q == IDX_LAST) begin
                        state_q <= S_IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus drive: core pass-through when idle, DMA addresses otherwise.
    always_comb begin
        bus.O_addr    = bus.I_cpu_addr;
        bus.O_wr_data = bus.I_cpu_wr_data;
        bus.O_rdwr    = bus.I_cpu_rdwr;
        unique case (state_q)
            S_IDLE: begin
            end
            S_READ: begin
                bus.O_addr = {page_q, index_q};
                bus.O_rdwr = 1'b1;
            end
            S_WRITE: begin
                bus.O_addr    = DMA_DST_ADDR;
                bus.O_wr_data = data_q;
                bus.O_rdwr    = 1'b0;
            end
            default: bus.O_rdwr = 1'b1;
        endcase
    end

    assign bus.O_cpu_ready = rdy_q & I_ready;
    assign bus.O_dma_busy  = (state_q != S_IDLE);
    assign bus.O_phy2      = (cnt_q >= CNT_HALF);
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: randomized core traffic and page transfers,
// checked cycle by cycle against a transfer-schedule model.
module tb_oam_dma_arbiter;
    localparam int CT  = 12;
    localparam int LEN = 256;
    localparam logic [15:0] REG = 16'h4014;
    localparam logic [15:0] DST = 16'h2004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy_in = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    oam_dma_arbiter_if bus ();

    oam_dma_arbiter #(
        .CYCLE_TICKS (CT),
        .DMA_REG_ADDR(REG),
        .DMA_DST_ADDR(DST),
        .DMA_LENGTH  (LEN)
    ) dut (
        .I_clock(clk),
        .I_reset(rst_n),
        .I_ready(rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memval(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    assign bus.I_rd_data = memval(bus.O_addr);

    // Expected bus behaviour k cycles after the trigger write.
    function automatic void dma_expect(
        input  int k, input int first, input int last,
        input  logic [7:0] pg, input logic [15:0] ca,
        output logic er, output logic eb,
        output logic [15:0] ea, output logic erw,
        output logic [7:0] ewd, output bit wchk);
        int j;
        er = (k > last);
        eb = (k <= last);
        ea = ca;
        erw = 1'b1;
        ewd = 8'h00;
        wchk = 1'b0;
        if (k >= first && k <= last) begin
            j = k - first;
            if (j % 2 == 0) begin
                ea = {pg, 8'(j / 2)};
            end else begin
                ea = DST;
                erw = 1'b0;
                ewd = memval({pg, 8'(j / 2)});
                wchk = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic [15:0] a, input logic [7:0] d,
                         input logic rw);
        bus.I_cpu_addr    = a;
        bus.I_cpu_wr_data = d;
        bus.I_cpu_rdwr    = rw;
    endtask

    task automatic bus_cyc(
        output logic rdy, output logic busy, output logic [15:0] a,
        output logic [7:0] wd, output logic rw,
        output logic p_lo, output logic p_hi);
        for (int t = 0; t < CT; t++) begin
            @(posedge clk);
            #1;
            if (t == CT / 2 - 2) p_lo = bus.O_phy2;
            if (t == CT / 2 - 1) begin
                p_hi = bus.O_phy2;
                rdy  = bus.O_cpu_ready;
                busy = bus.O_dma_busy;
                a    = bus.O_addr;
                wd   = bus.O_wr_data;
                rw   = bus.O_rdwr;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rdy_in = 1'b1;
        drive(16'h1234, 8'hA5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.O_cpu_ready !== 1'b1 || bus.O_dma_busy !== 1'b0 ||
            bus.O_phy2 !== 1'b0)
            $display("FAIL reset rdy/busy/phy2 got %b%b%b want 100",
                     bus.O_cpu_ready, bus.O_dma_busy, bus.O_phy2);
        checks++;
        if (bus.O_addr !== 16'h1234 || bus.O_rdwr !== 1'b1)
            $display("FAIL reset_mirror got %h/%b want 1234/1",
                     bus.O_addr, bus.O_rdwr);
        errors += (bus.O_cpu_ready !== 1'b1 || bus.O_dma_busy !== 1'b0 ||
                   bus.O_phy2 !== 1'b0) ? 1 : 0;
        errors += (bus.O_addr !== 16'h1234 || bus.O_rdwr !== 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_idle();
        logic r, b, rw, pl, ph;
        logic [15:0] a, ia;
        logic [7:0] wd, id;
        logic irw;
        for (int i = 0; i < 20; i++) begin
            ia  = 16'($urandom);
            id  = 8'($urandom);
            irw = 1'($urandom);
            if (ia == REG) irw = 1'b1;
            drive(ia, id, irw);
            bus_cyc(r, b, a, wd, rw, pl, ph);
            checks++;
            if (r !== 1'b1 || b !== 1'b0) begin
                errors++;
                $display("FAIL idle_rdy i=%0d got %b%b want 10", i, r, b);
            end
            checks++;
            if (a !== ia || wd !== id || rw !== irw) begin
                errors++;
                $display("FAIL idle_mirror i=%0d got %h/%h/%b want %h/%h/%b",
                         i, a, wd, rw, ia, id, irw);
            end
            checks++;
            if (pl !== 1'b0 || ph !== 1'b1) begin
                errors++;
                $display("FAIL phy2_edge i=%0d got %b%b want 01", i, pl, ph);
            end
        end
        rdy_in = 1'b0;
        #1;
        checks++;
        if (bus.O_cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_and got %b want 0", bus.O_cpu_ready);
        end
        rdy_in = 1'b1;
        #1;
        checks++;
        if (bus.O_cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_and_rel got %b want 1", bus.O_cpu_ready);
        end
    endtask

    task automatic test_no_trigger();
        logic r, b, rw, pl, ph;
        logic [15:0] a;
        logic [7:0] wd;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(REG, 8'h02, 1'b1);
            else if (i == 1) drive(16'h4015, 8'h02, 1'b0);
            else drive(16'h8000 + 16'(i), 8'h00, 1'b1);
            bus_cyc(r, b, a, wd, rw, pl, ph);
            checks++;
            if (r !== 1'b1 || b !== 1'b0) begin
                errors++;
                $display("FAIL no_trigger i=%0d got rdy %b busy %b want 1 0",
                         i, r, b);
            end
        end
    endtask

    task automatic test_dma(input string nm, input logic [7:0] pg,
                            input bit halt_even, input int stall_b,
                            input int rst_b);
        logic r, b, rw, pl, ph;
        logic er, eb, erw;
        logic [15:0] a, ea, ca;
        logic [7:0] wd, ewd;
        bit wchk, al;
        int first, last, low, n;
        if ((((cyc + 1) % 2) == 0) != halt_even) begin
            drive(16'h8000, 8'h00, 1'b1);
            bus_cyc(r, b, a, wd, rw, pl, ph);
        end
        n  = cyc;
        al = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        al = (n % 2) == 1;
`endif
        first = al ? 3 : 2;
        last  = first + 2 * LEN - 1;
        drive(REG, pg, 1'b0);
        bus_cyc(r, b, a, wd, rw, pl, ph);
        checks++;
        if (r !== 1'b1 || b !== 1'b0 || a !== REG || rw !== 1'b0) begin
            errors++;
            $display("FAIL %s trigger got %b%b %h %b want 11 %h 0",
                     nm, r, b, a, rw, REG);
        end
        ca = 16'hC000 | 16'($urandom_range(0, 16'h0FFF));
        drive(ca, 8'($urandom), 1'b1);
        low = 0;
        for (int k = 1; k <= last + 2; k++) begin
            dma_expect(k, first, last, pg, ca, er, eb, ea, erw, ewd, wchk);
            if (rst_b >= 0 && k == first + 2 * rst_b) begin
                repeat (4) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if (bus.O_cpu_ready !== 1'b1 || bus.O_dma_busy !== 1'b0 ||
                    bus.O_phy2 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_reset got %b%b%b want 100", nm,
                             bus.O_cpu_ready, bus.O_dma_busy, bus.O_phy2);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                cyc = 0;
                return;
            end
            if (stall_b >= 0 && k == first + 2 * stall_b) begin
                for (int t = 0; t < CT; t++) begin
                    if (t == 5) begin
                        rdy_in = 1'b0;
                        for (int s = 0; s < 30; s++) begin
                            @(posedge clk);
                            #1;
                            checks++;
                            if (bus.O_addr !== ea || bus.O_phy2 !== 1'b0) begin
                                errors++;
                                $display("FAIL %s stall s=%0d got %h/%b want %h/0",
                                         nm, s, bus.O_addr, bus.O_phy2, ea);
                            end
                        end
                        rdy_in = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                    if (t == 5) begin
                        checks++;
                        if (bus.O_phy2 !== 1'b1) begin
                            errors++;
                            $display("FAIL %s stall_resume phy2 got %b want 1",
                                     nm, bus.O_phy2);
                        end
                    end
                    if (t == CT / 2 - 1) begin
                        r  = bus.O_cpu_ready;
                        b  = bus.O_dma_busy;
                        a  = bus.O_addr;
                        wd = bus.O_wr_data;
                        rw = bus.O_rdwr;
                    end
                end
                cyc++;
            end else begin
                bus_cyc(r, b, a, wd, rw, pl, ph);
            end
            if (r === 1'b0) low++;
            checks++;
            if (r !== er || b !== eb) begin
                errors++;
                $display("FAIL %s k=%0d rdy/busy got %b%b want %b%b",
                         nm, k, r, b, er, eb);
            end
            checks++;
            if (a !== ea || rw !== erw) begin
                errors++;
                $display("FAIL %s k=%0d addr/rw got %h/%b want %h/%b",
                         nm, k, a, rw, ea, erw);
            end
            if (wchk) begin
                checks++;
                if (wd !== ewd) begin
                    errors++;
                    $display("FAIL %s k=%0d wdata got %h want %h",
                             nm, k, wd, ewd);
                end
            end
        end
        checks++;
        if (low != (al ? 514 : 513)) begin
            errors++;
            $display("FAIL %s halt_len got %0d want %0d",
                     nm, low, al ? 514 : 513);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_no_trigger();
        test_dma("halt_odd", 8'h02, 1'b0, -1, -1);
        test_dma("halt_even", 8'h02, 1'b1, -1, -1);
        test_dma("stall", 8'h02, 1'b0, 100, -1);
        test_dma("reset_mid", 8'h02, 1'b1, -1, 100);
        test_dma("after_reset", 8'h03, 1'b0, -1, -1);
        test_no_trigger();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
